synfull_delivery_buffer: RTL

- Receive-side counterpart of the SynFull request-to-injector path.
- Captures single-cycle ejection pulses from one endpoint's packet_injector (pck_injct_out id/size/source) into a first-word-fall-through queue.
- Returns them to the SynFull DPI delivery port over a valid/ready handshake, so the traffic model may stall without losing deliveries.
- Keeps per-endpoint received packet and flit statistics, plus an end-of-run drain handshake.

---
 rtl/pronoc_pkg.sv | 23 ++
 rtl/synfull_del_fifo.sv | 64 ++++++
 rtl/synfull_delivery_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pronoc_pkg.sv
// Shared types for the SynFull delivery buffer: the record kept per queued
// ejection and the drain sequencing states. Record field widths follow the
// default endpoint-id and packet-size widths of the delivery buffer.
package pronoc_pkg;

   localparam int DEF_NEW      = 4;
   localparam int DEF_PCK_SIZW = 6;
   localparam int TSTAMP_W     = 64;

   typedef struct packed {
      logic [31:0]             id;
      logic [DEF_PCK_SIZW-1:0] size;
      logic [DEF_NEW-1:0]      src;
      logic [TSTAMP_W-1:0]     tstamp;
   } del_rec_t;

   typedef enum logic [1:0] {
      DRN_RUN   = 2'd0,
      DRN_DRAIN = 2'd1,
      DRN_DONE  = 2'd2
   } drain_state_t;

endpackage

// File: rtl/synfull_del_fifo.sv
// First-word-fall-through register-array queue. The head entry is read
// straight from the array at rd_ptr; a push into a full queue is accepted
// only when the head is popped in the same cycle.
module synfull_del_fifo #(
   parameter int W      = 8,
   parameter int DEPTH  = 16,
   parameter int DEPTHw = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [W-1:0]      din,
   input  logic              pop,
   output logic [W-1:0]      dout,
   output logic              valid,
   output logic              push_ok,
   output logic [DEPTHw:0]   occ
);

   localparam logic [DEPTHw:0]   OCC_FULL = (DEPTHw+1)'(DEPTH);
   localparam logic [DEPTHw:0]   OCC_ONE  = (DEPTHw+1)'(1);
   localparam logic [DEPTHw-1:0] PTR_ONE  = DEPTHw'(1);

   logic [W-1:0]      mem [DEPTH];
   logic [DEPTHw-1:0] wr_ptr;
   logic [DEPTHw-1:0] rd_ptr;
   logic              pop_ok;
   logic              full;

   assign valid   = (occ != '0);
   assign full    = (occ == OCC_FULL);
   assign pop_ok  = pop && valid;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap modulo DEPTH; occupancy disambiguates full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/synfull_delivery_buffer.sv
// SynFull delivery buffer: queues ejection pulses from a packet_injector and
// hands them to the traffic model over valid/ready, with receive statistics
// and an end-of-run drain handshake.
// Optional build macro SYNFULL_DEL_TIMESTAMP_EN: stores the arrival cycle
// with each entry and presents it on del_tstamp_o (tied to 0 otherwise).
//
// Drain FSM
//   state     | meaning
//   DRN_RUN   | normal operation, no drain requested
//   DRN_DRAIN | drain requested, queue not yet empty (or ejection arriving)
//   DRN_DONE  | drain requested and queue empty; drain_done_o = 1
module synfull_delivery_buffer
   import pronoc_pkg::*;
#(
   parameter int NEw      = DEF_NEW,
   parameter int PCK_SIZw = DEF_PCK_SIZW,
   parameter int DEPTH    = 16,
   parameter int DEPTHw   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ej_valid_i,
   input  logic [31:0]         ej_id_i,
   input  logic [PCK_SIZw-1:0] ej_size_i,
   input  logic [NEw-1:0]      ej_src_i,
   output logic                del_valid_o,
   input  logic                del_ready_i,
   output logic [31:0]         del_id_o,
   output logic [PCK_SIZw-1:0] del_size_o,
   output logic [NEw-1:0]      del_src_o,
   output logic [63:0]         del_tstamp_o,
   input  logic                drain_req_i,
   output logic                drain_done_o,
   output logic                overflow_o,
   output logic [63:0]         rcv_pck_cnt_o,
   output logic [63:0]         rcv_flit_cnt_o,
   output logic [31:0]         drop_cnt_o,
   output logic [DEPTHw:0]     occ_o
);

   del_rec_t head_rec;
   logic     fifo_valid;
   logic     push_ok;

`ifdef SYNFULL_DEL_TIMESTAMP_EN
   localparam int FIFO_W = $bits(del_rec_t);

   logic [FIFO_W-1:0] fifo_din;
   logic [FIFO_W-1:0] fifo_dout;
   logic [63:0]       cyc_cnt;
   del_rec_t          wr_rec;

   // Free-running cycle counter sampled into each entry at its push edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 64'd1;
      end
   end

   // Assemble the stored record including the arrival stamp.
   always_comb begin
      wr_rec        = '0;
      wr_rec.id     = ej_id_i;
      wr_rec.size   = ej_size_i;
      wr_rec.src    = ej_src_i;
      wr_rec.tstamp = cyc_cnt;
   end

   assign fifo_din = wr_rec;
   assign head_rec = fifo_dout;
`else
   // Without stamps only id/size/src are stored; the stamp field reads 0.
   localparam int FIFO_W = $bits(del_rec_t) - TSTAMP_W;

   logic [FIFO_W-1:0] fifo_din;
   logic [FIFO_W-1:0] fifo_dout;

   assign fifo_din = {ej_id_i, ej_size_i, ej_src_i};
   assign head_rec = {fifo_dout, {TSTAMP_W{1'b0}}};
`endif

   synfull_del_fifo #(
      .W      (FIFO_W),
      .DEPTH  (DEPTH),
      .DEPTHw (DEPTHw)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (ej_valid_i),
      .din     (fifo_din),
      .pop     (del_ready_i),
      .dout    (fifo_dout),
      .valid   (fifo_valid),
      .push_ok (push_ok),
      .occ     (occ_o)
   );

   // Head fields are masked with valid so an empty queue presents zeros.
   assign del_valid_o  = fifo_valid;
   assign del_id_o     = fifo_valid ? head_rec.id     : '0;
   assign del_size_o   = fifo_valid ? head_rec.size   : '0;
   assign del_src_o    = fifo_valid ? head_rec.src    : '0;
   assign del_tstamp_o = fifo_valid ? head_rec.tstamp : '0;

   // Receive statistics: accepted pushes count, rejected ejections are drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcv_pck_cnt_o  <= '0;
         rcv_flit_cnt_o <= '0;
         drop_cnt_o     <= '0;
         overflow_o     <= 1'b0;
      end else if (push_ok) begin
         rcv_pck_cnt_o  <= rcv_pck_cnt_o + 64'd1;
         rcv_flit_cnt_o <= rcv_flit_cnt_o + 64'(ej_size_i);
      end else if (ej_valid_i) begin
         overflow_o <= 1'b1;
         if (drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + 32'd1;
         end
      end
   end

   drain_state_t state;

   // Drain sequencing; drain_done_o is registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= DRN_RUN;
         drain_done_o <= 1'b0;
      end else if (!drain_req_i) begin
         state        <= DRN_RUN;
         drain_done_o <= 1'b0;
      end else begin
         case (state)
            DRN_RUN: begin
               state        <= DRN_DRAIN;
               drain_done_o <= 1'b0;
            end
            DRN_DRAIN: begin
               if ((occ_o == '0) && !ej_valid_i) begin
                  state        <= DRN_DONE;
                  drain_done_o <= 1'b1;
               end
            end
            DRN_DONE: begin
               if (ej_valid_i) begin
                  state        <= DRN_DRAIN;
                  drain_done_o <= 1'b0;
               end
            end
            default: begin
               state        <= DRN_RUN;
               drain_done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
